blink_sequencer: RTL and testbench

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

---
 rtl/blink_sequencer_pkg.sv | 18 +
 rtl/blink_sequencer_tick_prescaler.sv | 54 +++++
 rtl/blink_sequencer.sv | 137 +++++++++++++
 tb/tb_blink_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_sequencer_pkg.sv
// Shared definitions for the blink sequencer: FSM state encoding and the
// default prescaler constants (1 Hz / 4 Hz blink from a 100 MHz clock).
package blink_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_DIV_W   = 27;
  localparam int unsigned DEF_SLOW_TC = 49_999_999;
  localparam int unsigned DEF_FAST_TC = 12_499_999;
  localparam int unsigned DEF_BLINKS  = 8;
  localparam int unsigned DEF_CNT_W   = 4;

endpackage

// File: rtl/blink_sequencer_tick_prescaler.sv
// tick_prescaler: half-period counter used as a clock enable.
// Ports:
//   clk        system clock
//   i_rst_n    asynchronous active-low reset
//   i_clr      synchronous clear of the counter (has priority over i_en)
//   i_en       count enable
//   i_sel_fast terminal count select (1 = FAST_TC, 0 = SLOW_TC)
//   o_term     registered one-cycle pulse, high the cycle after the counter
//              reached the selected terminal count
module tick_prescaler
  import blink_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned SLOW_TC = DEF_SLOW_TC,
  parameter int unsigned FAST_TC = DEF_FAST_TC
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_sel_fast,
  output logic o_term
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_term;
  logic [DIV_W-1:0] w_tc;
  logic             w_hit;

  assign w_tc   = i_sel_fast ? DIV_W'(FAST_TC) : DIV_W'(SLOW_TC);
  assign w_hit  = (r_cnt == w_tc);
  assign o_term = r_term;

  // Equality compare only: the counter never runs past the terminal count.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_term <= 1'b0;
    end else begin
      r_term <= 1'b0;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en) begin
        if (w_hit) begin
          r_cnt  <= '0;
          r_term <= 1'b1;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: blinks led BLINKS times at a start-selected rate, with
// pause/resume/abort control.
// Ports:
//   clk        system clock (only clock)
//   rst        asynchronous active-low reset
//   start      request pulse: start from IDLE, resume from PAUSE
//   stop       request pulse: pause from RUN, abort from PAUSE (wins over start)
//   fast       rate select, captured only when start is accepted in IDLE
//   led        blink output
//   tick       one-cycle pulse on every led toggle
//   busy       high in RUN and PAUSE
//   done       one-cycle pulse on sequence completion
//   blink_cnt  completed blinks in the current sequence
module blink_sequencer
  import blink_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned SLOW_TC = DEF_SLOW_TC,
  parameter int unsigned FAST_TC = DEF_FAST_TC,
  parameter int unsigned BLINKS  = DEF_BLINKS,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             fast,
  output logic             led,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] blink_cnt
);

  state_t           r_state;
  logic             r_led;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;
  logic             r_fast;
  logic [CNT_W-1:0] r_blink_cnt;

  logic             w_accept;
  logic             w_abort;
  logic             w_en;
  logic             w_term;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;

  assign w_accept  = (r_state == ST_IDLE)  && start && !stop;
  assign w_abort   = (r_state == ST_PAUSE) && stop;
  // The edge that samples stop already freezes the prescaler.
  assign w_en      = (r_state == ST_RUN)   && !stop;
  assign w_cnt_nxt = r_blink_cnt + CNT_W'(1);
  // Falling toggle that completes the final blink.
  assign w_last    = w_term && r_led && (w_cnt_nxt == CNT_W'(BLINKS));

  tick_prescaler #(
    .DIV_W   (DIV_W),
    .SLOW_TC (SLOW_TC),
    .FAST_TC (FAST_TC)
  ) u_prescaler (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_clr      (w_accept || w_abort),
    .i_en       (w_en),
    .i_sel_fast (r_fast),
    .o_term     (w_term)
  );

  // Sequencer FSM with registered outputs.
  // A terminal pulse pending in RUN is always consumed, even on a stop edge,
  // so no toggle is lost across a pause; completing the last blink beats stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_led       <= 1'b0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fast      <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_RUN;
            r_fast      <= fast;
            r_led       <= 1'b0;
            r_blink_cnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_term) begin
            r_led  <= ~r_led;
            r_tick <= 1'b1;
            if (r_led) begin
              r_blink_cnt <= w_cnt_nxt;
            end
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (stop) begin
            r_state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (start) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign led       = r_led;
  assign tick      = r_tick;
  assign busy      = r_busy;
  assign done      = r_done;
  assign blink_cnt = r_blink_cnt;

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: directed scenarios plus random start/stop/fast
// traffic, compared every cycle against a toggle-count reference model.
module tb_blink_sequencer;

  localparam int unsigned DIV_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SLOW   = 3;
  localparam int unsigned FAST   = 1;
  localparam int unsigned BLINKS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             fast;
  logic             led;
  logic             tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] blink_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: toggle j of a sequence happens on the first RUN edge
  // after the prescaler has been enabled for j*(TC+1) edges.
  int   m_mode;
  int   m_c;
  int   m_tog;
  int   m_tc;
  int   m_cnt;
  logic m_led;
  logic m_tick;
  logic m_busy;
  logic m_done;

  blink_sequencer #(
    .DIV_W   (DIV_W),
    .SLOW_TC (SLOW),
    .FAST_TC (FAST),
    .BLINKS  (BLINKS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .fast      (fast),
    .led       (led),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .blink_cnt (blink_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_c = 0; m_tog = 0; m_tc = 0; m_cnt = 0;
    m_led = 1'b0; m_tick = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic sp, input logic f);
    bit fin;
    fin    = 1'b0;
    m_tick = 1'b0;
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (st && !sp) begin
          m_mode = M_RUN;
          m_tc   = f ? int'(FAST) : int'(SLOW);
          m_c = 0; m_tog = 0; m_cnt = 0;
          m_led = 1'b0; m_busy = 1'b1;
        end
      end
      M_RUN: begin
        if (m_c == (m_tog + 1) * (m_tc + 1)) begin
          m_tog++;
          m_led  = ~m_led;
          m_tick = 1'b1;
          if (!m_led) begin
            m_cnt++;
            if (m_cnt == int'(BLINKS)) fin = 1'b1;
          end
        end
        if (fin) begin
          m_mode = M_DONE; m_done = 1'b1; m_busy = 1'b0;
        end else if (sp) begin
          m_mode = M_PAUSE;
        end else begin
          m_c++;
        end
      end
      M_PAUSE: begin
        if (sp) begin
          m_mode = M_IDLE; m_led = 1'b0; m_busy = 1'b0;
        end else if (st) begin
          m_mode = M_RUN;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock edge with the given inputs, then a full output comparison.
  task automatic step(input logic st, input logic sp, input logic f);
    @(negedge clk);
    start = st; stop = sp; fast = f;
    @(posedge clk);
    model_edge(st, sp, f);
    #1;
    check("cyc_led",  32'(led),       32'(m_led));
    check("cyc_tick", 32'(tick),      32'(m_tick));
    check("cyc_busy", 32'(busy),      32'(m_busy));
    check("cyc_done", 32'(done),      32'(m_done));
    check("cyc_cnt",  32'(blink_cnt), 32'(m_cnt));
  endtask

  // Slow sequence from IDLE; optional start+fast poke at poke_edge.
  task automatic slow_seq(input string tag, input int poke_edge);
    int   rise_e[2];
    int   fall_e[2];
    int   nr, nf, done_e;
    logic prev;
    rise_e = '{-1, -1}; fall_e = '{-1, -1};
    nr = 0; nf = 0; done_e = -1;
    step(1'b1, 1'b0, 1'b0);
    prev = led;
    for (int e = 1; e <= 24; e++) begin
      if (e == poke_edge) step(1'b1, 1'b0, 1'b1);
      else                step(1'b0, 1'b0, 1'(e & 1));
      if (!prev && led && nr < 2) begin rise_e[nr] = e; nr++; end
      if (prev && !led && nf < 2) begin fall_e[nf] = e; nf++; end
      if (done && done_e < 0) done_e = e;
      prev = led;
    end
    check({tag, "_rise0"}, 32'(rise_e[0]), 32'd5);
    check({tag, "_fall0"}, 32'(fall_e[0]), 32'd9);
    check({tag, "_rise1"}, 32'(rise_e[1]), 32'd13);
    check({tag, "_fall1"}, 32'(fall_e[1]), 32'd17);
    check({tag, "_done"},  32'(done_e),    32'd17);
    check({tag, "_cnt"},   32'(blink_cnt), 32'd2);
  endtask

  initial begin
    int ticks, done_e, rise_e;
    rst = 1'b0; start = 1'b0; stop = 1'b0; fast = 1'b0;
    model_reset();
    #1;
    check("rst_led",  32'(led),       32'd0);
    check("rst_busy", 32'(busy),      32'd0);
    check("rst_done", 32'(done),      32'd0);
    check("rst_cnt",  32'(blink_cnt), 32'd0);
    @(posedge clk); #2; rst = 1'b1;

    // Slow sequence, start on first edge after reset release.
    slow_seq("slow", -1);

    // Fast sequence: 2-cycle half period, 4 ticks, done after edge 9.
    ticks = 0; done_e = -1; rise_e = -1;
    step(1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 14; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (tick) ticks++;
      if (led && rise_e < 0) rise_e = e;
      if (done && done_e < 0) done_e = e;
    end
    check("fast_ticks", 32'(ticks),  32'd4);
    check("fast_rise",  32'(rise_e), 32'd3);
    check("fast_done",  32'(done_e), 32'd9);

    // Pause at prescaler=2, hold 5 cycles, resume.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check("pause_led",  32'(led),       32'd0);
      check("pause_cnt",  32'(blink_cnt), 32'd0);
      check("pause_busy", 32'(busy),      32'd1);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("resume_pre", 32'(led), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("resume_led",  32'(led),  32'd1);
    check("resume_tick", 32'(tick), 32'd1);
    // Pause then abort with led high: led clears, no done.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("abort_led",  32'(led),  32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    // In PAUSE, start and stop together: abort.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("both_busy", 32'(busy), 32'd0);
    check("both_led",  32'(led),  32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("both_done", 32'(done), 32'd0);
    // In IDLE, start and stop together stay idle.
    step(1'b1, 1'b1, 1'b1);
    check("idle_both_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN with led high.
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 6; e++) step(1'b0, 1'b0, 1'b0);
    check("pre_rst_led", 32'(led), 32'd1);
    @(negedge clk); start = 1'b0; stop = 1'b0;
    #2; rst = 1'b0;
    #1;
    check("arst_led",  32'(led),       32'd0);
    check("arst_busy", 32'(busy),      32'd0);
    check("arst_tick", 32'(tick),      32'd0);
    check("arst_done", 32'(done),      32'd0);
    check("arst_cnt",  32'(blink_cnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("arst_hold_done", 32'(done), 32'd0);
    #1; rst = 1'b1;
    slow_seq("after_rst", -1);

    // Start+fast while running is ignored.
    slow_seq("ignore", 2);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      step(1'(($urandom_range(0, 7) == 0)), 1'(($urandom_range(0, 15) == 0)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
